clk_rate_ctrl: RTL and testbench

//   Run-time controller for the modulator's divided timebase. Produces a one-cycle

---
 rtl/clk_rate_ctrl.sv | 114 +++++++++++
 tb/tb_clk_rate_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rate_ctrl.sv
// clk_rate_ctrl: run-time controller for a divided timebase.
// Emits a one-cycle o_tick every o_div cycles of i_clk. Start/stop sequencing
// lets the current period finish before going idle. New divisors are taken
// over a valid/ready handshake and applied only on period boundaries.
// Optional feature: define CLK_RATE_CTRL_CLKOUT_EN to add the o_clk square
// wave output, which toggles on every tick (period 2*o_div).
module clk_rate_ctrl #(
  parameter int               NBITS   = 8,
  parameter logic [NBITS-1:0] DEF_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_cfg_valid,
  input  logic [NBITS-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_tick,
  output logic             o_busy,
  output logic [NBITS-1:0] o_div
`ifdef CLK_RATE_CTRL_CLKOUT_EN
  ,
  output logic             o_clk
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state;
  logic [NBITS-1:0] cnt;
  logic [NBITS-1:0] pend_div;

  logic cfg_xfer;
  logic cfg_nonzero;
  logic at_wrap;

  // Handshake and period-boundary decode, shared by every branch of the FSM.
  always_comb begin
    cfg_xfer    = i_cfg_valid & o_cfg_ready;
    cfg_nonzero = (i_cfg_div != '0);
    at_wrap     = (cnt == o_div - 1'b1);
  end

  // Busy reflects the state register directly, so it is glitch-free.
  assign o_busy = (state != IDLE);

  // FSM, period counter, divisor handshake and tick generation.
  // NOTE: every register here is assigned with <= so all updates see the
  // pre-edge values; mixing = in a clocked block creates order-dependent logic.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pend_div    <= '0;
      o_tick      <= 1'b0;
      o_cfg_ready <= 1'b1;
      o_div       <= DEF_DIV;
`ifdef CLK_RATE_CTRL_CLKOUT_EN
      o_clk       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Counter and tick are frozen; a divisor offered here applies at once,
          // so a simultaneous start runs its first period with the new value.
          o_tick <= 1'b0;
          cnt    <= '0;
          if (cfg_xfer && cfg_nonzero) o_div <= i_cfg_div;
          if (i_start) state <= RUN;
        end

        RUN, STOPPING: begin
          if (at_wrap) begin
            o_tick <= 1'b1;
            cnt    <= '0;
`ifdef CLK_RATE_CTRL_CLKOUT_EN
            o_clk  <= ~o_clk;
`endif
            // Ready low means a divisor is waiting for this boundary.
            if (!o_cfg_ready) begin
              o_div       <= pend_div;
              o_cfg_ready <= 1'b1;
            end
          end else begin
            o_tick <= 1'b0;
            cnt    <= cnt + 1'b1;
          end

          // A transfer only happens with ready high, so it never collides with
          // the pending-apply path above. A zero divisor is accepted and dropped.
          if (cfg_xfer && cfg_nonzero) begin
            pend_div    <= i_cfg_div;
            o_cfg_ready <= 1'b0;
          end

          if (state == RUN) begin
            if (i_stop) state <= STOPPING;
          end else begin
            // Start cancels the stop without touching the counter phase.
            if (i_start)      state <= RUN;
            else if (at_wrap) state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// tb_clk_rate_ctrl: directed self-checking bench for clk_rate_ctrl.
// Cycle numbering: cycle 0 is the edge that samples i_start; outputs are
// sampled 1 ns after each rising edge.
module tb_clk_rate_ctrl;

  localparam int NBITS = 8;

  logic             i_clk;
  logic             i_rst;
  logic             i_start;
  logic             i_stop;
  logic             i_cfg_valid;
  logic [NBITS-1:0] i_cfg_div;
  logic             o_cfg_ready;
  logic             o_tick;
  logic             o_busy;
  logic [NBITS-1:0] o_div;
`ifdef CLK_RATE_CTRL_CLKOUT_EN
  logic             o_clk;
`endif

  int n_run  = 0;
  int n_fail = 0;

  clk_rate_ctrl #(.NBITS(NBITS), .DEF_DIV(8'd4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_div   (i_cfg_div),
    .o_cfg_ready (o_cfg_ready),
    .o_tick      (o_tick),
    .o_busy      (o_busy),
    .o_div       (o_div)
`ifdef CLK_RATE_CTRL_CLKOUT_EN
    ,
    .o_clk       (o_clk)
`endif
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_start     = 1'b0;
    i_stop      = 1'b0;
    i_cfg_valid = 1'b0;
    i_cfg_div   = '0;
    i_rst       = 1'b1;
    #2;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // Reset values, and stop being ignored while idle.
  task automatic test_reset();
    do_reset();
    n_run++; if (o_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick got=%b exp=0", o_tick); end
    n_run++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    n_run++; if (o_cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", o_cfg_ready); end
    n_run++; if (o_div !== 8'd4) begin n_fail++; $display("FAIL rst_div got=%0d exp=4", o_div); end
`ifdef CLK_RATE_CTRL_CLKOUT_EN
    n_run++; if (o_clk !== 1'b0) begin n_fail++; $display("FAIL rst_clk got=%b exp=0", o_clk); end
`endif
    i_stop = 1'b1;
    step(); step();
    i_stop = 1'b0;
    n_run++; if (o_busy !== 1'b0 || o_tick !== 1'b0) begin
      n_fail++; $display("FAIL idle_stop busy=%b tick=%b exp=0,0", o_busy, o_tick);
    end
  endtask

  // T1: default divisor, ticks at 4, 8, 12.
  task automatic test_basic_run();
    logic exp_tick;
    do_reset();
    i_start = 1'b1; step(); i_start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      step();
      exp_tick = (c % 4 == 0);
      n_run++; if (o_tick !== exp_tick) begin n_fail++; $display("FAIL t1_tick cyc=%0d got=%b exp=%b", c, o_tick, exp_tick); end
      n_run++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy cyc=%0d got=%b exp=1", c, o_busy); end
`ifdef CLK_RATE_CTRL_CLKOUT_EN
      n_run++; if (o_clk !== logic'((c / 4) % 2)) begin n_fail++; $display("FAIL t1_clk cyc=%0d got=%b", c, o_clk); end
`endif
    end
  endtask

  // T2: divisor 6 offered at cycle 5, applied at the tick of cycle 8.
  task automatic test_cfg_run();
    logic             exp_tick;
    logic             exp_rdy;
    logic [NBITS-1:0] exp_div;
    do_reset();
    i_start = 1'b1; step(); i_start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      i_cfg_valid = (c == 5);
      i_cfg_div   = (c == 5) ? 8'd6 : 8'd0;
      step();
      i_cfg_valid = 1'b0;
      exp_tick = (c == 4 || c == 8 || c == 14 || c == 20);
      exp_rdy  = !(c >= 5 && c <= 7);
      exp_div  = (c >= 8) ? 8'd6 : 8'd4;
      n_run++; if (o_tick !== exp_tick) begin n_fail++; $display("FAIL t2_tick cyc=%0d got=%b exp=%b", c, o_tick, exp_tick); end
      n_run++; if (o_cfg_ready !== exp_rdy) begin n_fail++; $display("FAIL t2_ready cyc=%0d got=%b exp=%b", c, o_cfg_ready, exp_rdy); end
      n_run++; if (o_div !== exp_div) begin n_fail++; $display("FAIL t2_div cyc=%0d got=%0d exp=%0d", c, o_div, exp_div); end
    end
  endtask

  // T3 (stop at 9, no resume) and T4 (stop at 9, start at 10).
  task automatic test_stop(input logic resume);
    logic exp_tick;
    logic exp_busy;
    do_reset();
    i_start = 1'b1; step(); i_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      i_stop  = (c == 9);
      i_start = resume && (c == 10);
      step();
      i_stop  = 1'b0;
      i_start = 1'b0;
      exp_tick = resume ? (c % 4 == 0) : (c == 4 || c == 8 || c == 12);
      exp_busy = resume ? 1'b1 : (c < 12);
      n_run++; if (o_tick !== exp_tick) begin n_fail++; $display("FAIL stop%0d_tick cyc=%0d got=%b exp=%b", resume, c, o_tick, exp_tick); end
      n_run++; if (o_busy !== exp_busy) begin n_fail++; $display("FAIL stop%0d_busy cyc=%0d got=%b exp=%b", resume, c, o_busy, exp_busy); end
    end
  endtask

  // T5: divisor 1 gives a constant tick; a zero divisor is discarded.
  task automatic test_div_one();
    do_reset();
    i_cfg_valid = 1'b1; i_cfg_div = 8'd1; step(); i_cfg_valid = 1'b0;
    n_run++; if (o_div !== 8'd1) begin n_fail++; $display("FAIL t5_div_idle got=%0d exp=1", o_div); end
    i_cfg_valid = 1'b1; i_cfg_div = 8'd0; step(); i_cfg_valid = 1'b0;
    n_run++; if (o_div !== 8'd1) begin n_fail++; $display("FAIL t5_zero_idle got=%0d exp=1", o_div); end
    i_start = 1'b1; step(); i_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      i_cfg_valid = (c == 3);
      i_cfg_div   = 8'd0;
      step();
      i_cfg_valid = 1'b0;
      n_run++; if (o_tick !== 1'b1) begin n_fail++; $display("FAIL t5_tick cyc=%0d got=%b exp=1", c, o_tick); end
      n_run++; if (o_div !== 8'd1) begin n_fail++; $display("FAIL t5_div cyc=%0d got=%0d exp=1", c, o_div); end
      n_run++; if (o_cfg_ready !== 1'b1) begin n_fail++; $display("FAIL t5_ready cyc=%0d got=%b exp=1", c, o_cfg_ready); end
    end
  endtask

  // Start and divisor 3 in the same idle cycle: first period already uses 3.
  task automatic test_back_to_back();
    logic exp_tick;
    do_reset();
    i_start = 1'b1; i_cfg_valid = 1'b1; i_cfg_div = 8'd3;
    step();
    i_start = 1'b0; i_cfg_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      exp_tick = (c % 3 == 0);
      n_run++; if (o_tick !== exp_tick) begin n_fail++; $display("FAIL b2b_tick cyc=%0d got=%b exp=%b", c, o_tick, exp_tick); end
    end
    n_run++; if (o_div !== 8'd3) begin n_fail++; $display("FAIL b2b_div got=%0d exp=3", o_div); end
  endtask

  // Start+stop together: start wins in IDLE, stop wins in RUN.
  task automatic test_priority();
    logic exp_tick;
    logic exp_busy;
    do_reset();
    i_start = 1'b1; i_stop = 1'b1; step(); i_start = 1'b0; i_stop = 1'b0;
    n_run++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL prio_idle_busy got=%b exp=1", o_busy); end
    for (int c = 1; c <= 12; c++) begin
      i_start = (c == 5);
      i_stop  = (c == 5);
      step();
      i_start = 1'b0;
      i_stop  = 1'b0;
      exp_tick = (c == 4 || c == 8);
      exp_busy = (c < 8);
      n_run++; if (o_tick !== exp_tick) begin n_fail++; $display("FAIL prio_tick cyc=%0d got=%b exp=%b", c, o_tick, exp_tick); end
      n_run++; if (o_busy !== exp_busy) begin n_fail++; $display("FAIL prio_busy cyc=%0d got=%b exp=%b", c, o_busy, exp_busy); end
    end
  endtask

  // T6: async reset mid-period with a divisor pending, then clean restart.
  task automatic test_async_reset();
    logic exp_tick;
    do_reset();
    i_cfg_valid = 1'b1; i_cfg_div = 8'd7; step(); i_cfg_valid = 1'b0;
    i_start = 1'b1; step(); i_start = 1'b0;
    step();
    i_cfg_valid = 1'b1; i_cfg_div = 8'd5; step(); i_cfg_valid = 1'b0;
    step();
    n_run++; if (o_cfg_ready !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL t6_pre ready=%b busy=%b exp=0,1", o_cfg_ready, o_busy);
    end
    #2;
    i_rst = 1'b1;
    #1;
    n_run++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL t6_busy got=%b exp=0", o_busy); end
    n_run++; if (o_cfg_ready !== 1'b1) begin n_fail++; $display("FAIL t6_ready got=%b exp=1", o_cfg_ready); end
    n_run++; if (o_div !== 8'd4) begin n_fail++; $display("FAIL t6_div got=%0d exp=4", o_div); end
    n_run++; if (o_tick !== 1'b0) begin n_fail++; $display("FAIL t6_tick got=%b exp=0", o_tick); end
    @(negedge i_clk);
    i_rst = 1'b0;
    i_start = 1'b1; step(); i_start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_tick = (c % 4 == 0);
      n_run++; if (o_tick !== exp_tick) begin n_fail++; $display("FAIL t6_restart_tick cyc=%0d got=%b exp=%b", c, o_tick, exp_tick); end
      n_run++; if (o_div !== 8'd4) begin n_fail++; $display("FAIL t6_restart_div cyc=%0d got=%0d exp=4", c, o_div); end
    end
  endtask

  initial begin
    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_stop      = 1'b0;
    i_cfg_valid = 1'b0;
    i_cfg_div   = '0;
    test_reset();
    test_basic_run();
    test_cfg_run();
    test_stop(1'b0);
    test_stop(1'b1);
    test_div_one();
    test_back_to_back();
    test_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
